// File: rtl/axi_lite_regbank.sv
// AXI4-Lite CSR slave: NUM_REGS byte-strobed registers, optional read-only status mapping,
// independent AW/W capture with a one-deep hold per channel.
module axi_lite_regbank #(
    parameter int unsigned             ADDR_WIDTH   = 32,
    parameter int unsigned             DATA_WIDTH   = 32,
    parameter int unsigned             STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned             NUM_REGS     = 8,
    parameter logic [NUM_REGS-1:0]     RO_MASK      = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_awvalid,
    input  logic [ADDR_WIDTH-1:0]          i_awaddr,
    output logic                           o_awready,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [STROBE_WIDTH-1:0]        i_wstrb,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [ADDR_WIDTH-1:0]          i_araddr,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [1:0]                     o_rresp,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_status,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);

    localparam int unsigned OFF_W = $clog2(STROBE_WIDTH);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Upper address bits take part in the range check, so compare the full word index.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> OFF_W) < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    logic                    aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STROBE_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]   status_w [NUM_REGS];

    logic             aw_fire, w_fire, ar_fire, commit;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic             w_in_range, r_in_range;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
        assign status_w[g] = i_status[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign o_awready  = ~aw_held_q;
    assign o_wready   = ~w_held_q;
    assign o_arready  = ~rvalid_q;
    assign o_bvalid   = bvalid_q;
    assign o_bresp    = bresp_q;
    assign o_rvalid   = rvalid_q;
    assign o_rresp    = rresp_q;
    assign o_rdata    = rdata_q;
    assign o_wr_pulse = wr_pulse_q;

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        regs_d     = regs_q;

        aw_fire    = i_awvalid & ~aw_held_q;
        w_fire     = i_wvalid & ~w_held_q;
        ar_fire    = i_arvalid & ~rvalid_q;
        commit     = aw_held_q & w_held_q & ~bvalid_q;
        w_idx      = addr_idx(aw_addr_q);
        w_in_range = addr_in_range(aw_addr_q);
        r_idx      = addr_idx(i_araddr);
        r_in_range = addr_in_range(i_araddr);

        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_addr_d = i_awaddr;
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            w_data_d = i_wdata;
            w_strb_d = i_wstrb;
        end
        if (bvalid_q && i_bready) begin
            bvalid_d = 1'b0;
        end

        // Commit only with the B channel free; holds may already be refilling meanwhile.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!w_in_range) begin
                bresp_d = RESP_DECERR;
            end else if (RO_MASK[w_idx]) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d           = RESP_OKAY;
                wr_pulse_d[w_idx] = 1'b1;
                for (int b = 0; b < STROBE_WIDTH; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[w_idx][b*8 +: 8] = w_data_q[b*8 +: 8];
                    end
                end
            end
        end

        if (rvalid_q && i_rready) begin
            rvalid_d = 1'b0;
        end
        // Read samples regs_q, so a same-edge commit is seen as the old value.
        if (ar_fire) begin
            rvalid_d = 1'b1;
            if (!r_in_range) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = RO_MASK[r_idx] ? status_w[r_idx] : regs_q[r_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level register model.
module tb_axi_lite_regbank;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned NR = 8;
    localparam logic [NR-1:0] RO = 8'h80;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic [AW-1:0]    i_awaddr, i_araddr;
    logic [SW-1:0]    i_wstrb;
    logic [DW-1:0]    i_wdata;
    logic             o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]       o_bresp, o_rresp;
    logic [DW-1:0]    o_rdata;
    logic [NR*DW-1:0] o_regs, i_status;
    logic [NR-1:0]    o_wr_pulse;

    axi_lite_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO),
                       .RESET_VALUE('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_regs(o_regs), .i_status(i_status), .o_wr_pulse(o_wr_pulse)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_b    = 0;

    logic [31:0] mregs [NR];
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    logic [31:0] ar_q [$];
    logic [1:0]  last_bresp, last_rresp;
    logic [31:0] last_rdata;
    logic [NR-1:0] last_pulse;
    logic        stop;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_ev(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got unexpected event, expected none", nm);
    endtask

    // Register model: byte-addressed words, 4 bytes per register, 32 bytes of decode space.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [35:0] wd,
                                               output logic [NR-1:0] pulse);
        int idx;
        pulse = '0;
        if (a >= 32'(NR * SW)) return 2'b11;
        idx = int'(a / 4);
        if (RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (wd[32+b]) mregs[idx][b*8 +: 8] = wd[b*8 +: 8];
        pulse[idx] = 1'b1;
        return 2'b00;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = mregs[i];
        return f;
    endfunction

    // Per-cycle compare: responses are checked on their first valid cycle, regs and pulses always.
    initial begin : compare
        logic pb, pr;
        logic [255:0] st;
        logic [31:0] a, ed;
        logic [35:0] wd;
        logic [1:0]  er;
        logic [NR-1:0] ep;
        pb = 1'b0;
        pr = 1'b0;
        forever begin
            @(posedge clk);
            st = i_status;
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0;
                pr = 1'b0;
                continue;
            end
            if (o_rvalid && !pr) begin
                if (ar_q.size() == 0) fail_ev("r_unexpected");
                else begin
                    a = ar_q.pop_front();
                    if (a >= 32'(NR * SW)) begin ed = '0; er = 2'b11; end
                    else if (RO[a / 4]) begin ed = st[(a / 4) * 32 +: 32]; er = 2'b00; end
                    else begin ed = mregs[a / 4]; er = 2'b00; end
                    chk("rdata", o_rdata, ed);
                    chk("rresp", o_rresp, er);
                    last_rdata = o_rdata;
                    last_rresp = o_rresp;
                end
            end
            ep = '0;
            if (o_bvalid && !pb) begin
                if (aw_q.size() == 0 || w_q.size() == 0) fail_ev("b_unexpected");
                else begin
                    a  = aw_q.pop_front();
                    wd = w_q.pop_front();
                    er = model_write(a, wd, ep);
                    chk("bresp", o_bresp, er);
                    last_bresp = o_bresp;
                    last_pulse = o_wr_pulse;
                    n_b++;
                end
            end
            chk("wr_pulse", o_wr_pulse, ep);
            chk("regs", o_regs, model_flat());
            pb = o_bvalid;
            pr = o_rvalid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        logic hs;
        i_awvalid = 1'b1;
        i_awaddr  = a;
        do begin @(negedge clk); hs = o_awready; @(posedge clk); #1; n++; end
        while (!hs && n < 300);
        if (!hs) fail_ev("aw_timeout"); else aw_q.push_back(a);
        i_awvalid = 1'b0;
        i_awaddr  = $urandom;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic hs;
        i_wvalid = 1'b1;
        i_wdata  = d;
        i_wstrb  = s;
        do begin @(negedge clk); hs = o_wready; @(posedge clk); #1; n++; end
        while (!hs && n < 300);
        if (!hs) fail_ev("w_timeout"); else w_q.push_back({s, d});
        i_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        int n = 0;
        logic hs;
        i_arvalid = 1'b1;
        i_araddr  = a;
        do begin @(negedge clk); hs = o_arready; @(posedge clk); #1; n++; end
        while (!hs && n < 300);
        if (!hs) fail_ev("ar_timeout"); else ar_q.push_back(a);
        i_arvalid = 1'b0;
        i_araddr  = $urandom;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            do_aw(a);
            do_w(d, s);
        join
    endtask

    task automatic wait_quiet();
        int n = 0;
        logic q;
        do begin
            @(negedge clk);
            q = aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0 &&
                !o_bvalid && !o_rvalid && o_awready && o_wready;
            n++;
        end while (!q && n < 500);
        if (!q) fail_ev("quiet_timeout");
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 9));
        if (r < 8) return 32'(r * 4) + 32'($urandom_range(0, 3));
        if (r == 8) return 32'h20 + 32'($urandom_range(0, 31));
        return $urandom | 32'h100;
    endfunction

    initial begin : main
        int nb0;
        rst_n = 1'b0;
        {i_awvalid, i_wvalid, i_arvalid} = '0;
        i_bready = 1'b1;
        i_rready = 1'b1;
        i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_wstrb = '0;
        i_status = '0;
        stop = 1'b0;
        last_bresp = '0; last_rresp = '0; last_rdata = '0; last_pulse = '0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        idle(3);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_resp", {o_bresp, o_rresp}, 0);
        chk("rst_pulse", o_wr_pulse, 0);
        chk("rst_ready", {o_awready, o_wready, o_arready}, 3'b111);
        rst_n = 1'b1;

        for (int i = 0; i < NR; i++) do_ar(32'(i * 4));
        wait_quiet();
        chk("t1_rdata", last_rdata, 32'h0);

        fork
            do_w(32'hDEADBEEF, 4'hF);
            begin idle(3); do_aw(32'h4); end
        join
        wait_quiet();
        chk("t2_bresp", last_bresp, 2'b00);
        chk("t2_pulse", last_pulse, 8'h02);
        chk("t2_reg1", o_regs[63:32], 32'hDEADBEEF);
        do_write(32'h4, 32'h0000AA00, 4'h2);
        wait_quiet();
        chk("t2_reg1_strb", o_regs[63:32], 32'hDEADAAEF);

        i_status[7*32 +: 32] = 32'h12345678;
        do_write(32'h1C, 32'hFFFFFFFF, 4'hF);
        wait_quiet();
        chk("t3_bresp", last_bresp, 2'b10);
        chk("t3_pulse", last_pulse, 8'h00);
        do_ar(32'h1C);
        wait_quiet();
        chk("t3_rdata", last_rdata, 32'h12345678);
        chk("t3_rresp", last_rresp, 2'b00);

        do_write(32'h20, 32'hCAFEF00D, 4'hF);
        wait_quiet();
        chk("t4_bresp", last_bresp, 2'b11);
        do_ar(32'h20);
        wait_quiet();
        chk("t4_rdata", last_rdata, 32'h0);
        chk("t4_rresp", last_rresp, 2'b11);
        chk("t4_reg1", o_regs[63:32], 32'hDEADAAEF);

        i_bready = 1'b0;
        nb0 = n_b;
        do_write(32'h8, 32'h11111111, 4'hF);
        do_write(32'hC, 32'h22222222, 4'hF);
        idle(10);
        chk("t5_holds_full", {o_awready, o_wready, o_bvalid}, 3'b001);
        chk("t5_one_b", 32'(n_b - nb0), 32'd1);
        chk("t5_reg3_pending", o_regs[127:96], 32'h0);
        i_bready = 1'b1;
        wait_quiet();
        chk("t5_two_b", 32'(n_b - nb0), 32'd2);
        chk("t5_regs", o_regs[127:64], 64'h22222222_11111111);

        fork
            begin : gen
                fork
                    for (int i = 0; i < 150; i++) begin
                        idle(int'($urandom_range(0, 3)));
                        do_aw(rand_addr());
                    end
                    for (int i = 0; i < 150; i++) begin
                        idle(int'($urandom_range(0, 3)));
                        do_w($urandom, 4'($urandom_range(0, 15)));
                    end
                    for (int i = 0; i < 150; i++) begin
                        idle(int'($urandom_range(0, 2)));
                        do_ar(rand_addr());
                    end
                join
                stop = 1'b1;
            end
            while (!stop) begin
                idle(1);
                i_bready = 1'($urandom_range(0, 1));
                i_rready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) i_status[7*32 +: 32] = $urandom;
            end
        join
        i_bready = 1'b1;
        i_rready = 1'b1;
        wait_quiet();

        do_aw(32'h4);
        idle(1);
        chk("t6_aw_held", o_awready, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        aw_q.delete();
        w_q.delete();
        ar_q.delete();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        chk("t6_async_regs", o_regs, 256'h0);
        chk("t6_async_ctrl", {o_bvalid, o_rvalid, o_wr_pulse, o_awready}, 11'h001);
        idle(2);
        rst_n = 1'b1;
        do_w(32'h55, 4'hF);
        idle(5);
        chk("t6_no_b", o_bvalid, 1'b0);
        do_aw(32'h8);
        wait_quiet();
        chk("t6_reg2", o_regs[95:64], 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
